// File: rtl/reg_scoreboard_pkg.sv
// Purpose: shared constants, index type and writeback-match popcount for the register scoreboard.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sb_pkg;

  localparam int NUM_REGS_DEF  = 32;
  localparam int REG_IDX_W_DEF = 5;
  localparam int ZERO_REG      = 0;
  // Upper bound on writeback ports handled by the match popcount.
  localparam int MAX_WB        = 8;

  typedef logic [REG_IDX_W_DEF-1:0] reg_idx_t;

  // Number of writeback ports hitting one register this cycle.
  // Duplicate ports on the same register count separately.
  function automatic int unsigned wb_match_count(input logic [MAX_WB-1:0] hits);
    int unsigned n;
    n = 0;
    for (int j = 0; j < MAX_WB; j++) begin
      if (hits[j]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Purpose: issue, writeback, flush and status bundle between the pipeline and the scoreboard.
// Latency: n/a (wires only).
// Backpressure: issue_stall holds decode; writeback and flush are never backpressured.
// master = pipeline side (decode/issue + writeback), slave = scoreboard.
interface reg_scoreboard_if
  import sb_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF,
  parameter int NUM_SRC   = 2,
  parameter int NUM_WB    = 2
);
  logic                           issue_valid;
  logic [NUM_SRC*REG_IDX_W-1:0]   issue_rs;
  logic [NUM_SRC-1:0]             issue_rs_used;
  logic                           issue_rd_valid;
  logic [REG_IDX_W-1:0]           issue_rd;
  logic                           issue_stall;
  logic [NUM_WB-1:0]              wb_valid;
  logic [NUM_WB*REG_IDX_W-1:0]    wb_rd;
  logic                           flush;
  logic [NUM_REGS-1:0]            busy_vec;
  logic                           any_pending;
  logic                           err_underflow;
  logic [31:0]                    stall_count;

  modport master (
    output issue_valid, issue_rs, issue_rs_used, issue_rd_valid, issue_rd,
    output wb_valid, wb_rd, flush,
    input  issue_stall, busy_vec, any_pending, err_underflow, stall_count
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rs_used, issue_rd_valid, issue_rd,
    input  wb_valid, wb_rd, flush,
    output issue_stall, busy_vec, any_pending, err_underflow, stall_count
  );
endinterface

// File: rtl/reg_scoreboard_entry.sv
// Purpose: outstanding-write counter for one architectural register.
// Latency: count updates one cycle after inc/dec; underflow is a same-cycle pulse.
// Backpressure: none; full tells the issue stage to stop adding writes.
// Ports: clk/reset, flush, inc (issue to this reg), dec (wb hits this cycle),
//        count, busy (count!=0), full (count at max), underflow (dec > count+inc).
module sb_entry #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             full,
  output logic             underflow
);
  // One extra bit so count+inc and dec compare without wrap.
  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] dec_x;

  always_comb begin
    sum       = SUM_W'(count) + SUM_W'(inc);
    dec_x     = SUM_W'(dec);
    underflow = (dec_x > sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (underflow) begin
      count <= '0;  // clamp rather than wrap on a spurious writeback
    end else begin
      count <= CNT_W'(sum - dec_x);
    end
  end

  assign busy = |count;
  assign full = &count;
endmodule

// File: rtl/reg_scoreboard.sv
// Purpose: RAW/WAW hazard scoreboard with per-register outstanding-write counters.
// Latency: issue_stall is combinational; busy_vec/err_underflow/stall_count update one cycle later.
// Backpressure: issue_stall holds decode on a source hazard or a full destination counter.
// Ports: clk, reset (sync, active-high), sb (slave side of reg_scoreboard_if).
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF,
  parameter int NUM_SRC   = 2,
  parameter int NUM_WB    = 2,
  parameter int CNT_W     = 2,
  parameter int BYPASS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);
  localparam int DEC_W = $clog2(NUM_WB + 1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy_v;
  logic [NUM_REGS-1:0] full_v;
  logic [NUM_REGS-1:0] uflow_v;
  logic [NUM_REGS-1:0] wb_hit;
  logic                stall;
  logic                fire;
  logic                src_haz;
  logic                waw;
  logic                err_q;
  logic [31:0]         stall_cnt_q;

  // x0 is hard-wired idle.
  assign cnt[ZERO_REG]     = '0;
  assign busy_v[ZERO_REG]  = 1'b0;
  assign full_v[ZERO_REG]  = 1'b0;
  assign uflow_v[ZERO_REG] = 1'b0;
  assign wb_hit[ZERO_REG]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    logic [MAX_WB-1:0] hits;
    logic              inc;

    always_comb begin
      hits = '0;
      for (int j = 0; j < NUM_WB; j++) begin
        hits[j] = sb.wb_valid[j] && (sb.wb_rd[j*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r));
      end
    end

    assign wb_hit[r] = |hits;
    assign inc       = fire && sb.issue_rd_valid && (sb.issue_rd == REG_IDX_W'(r));

    sb_entry #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .flush     (sb.flush),
      .inc       (inc),
      .dec       (DEC_W'(wb_match_count(hits))),
      .count     (cnt[r]),
      .busy      (busy_v[r]),
      .full      (full_v[r]),
      .underflow (uflow_v[r])
    );
  end

  // Sources are checked against pre-update counters, so an instruction
  // reading its own rd does not stall on itself.
  always_comb begin
    logic [REG_IDX_W-1:0] rs;
    src_haz = 1'b0;
    rs      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = sb.issue_rs[i*REG_IDX_W +: REG_IDX_W];
      if (sb.issue_rs_used[i] && (rs != '0) && (cnt[rs] != '0) &&
          !((BYPASS != 0) && (cnt[rs] == CNT_W'(1)) && wb_hit[rs])) begin
        src_haz = 1'b1;
      end
    end
    waw   = sb.issue_rd_valid && (sb.issue_rd != '0) && full_v[sb.issue_rd];
    stall = sb.issue_valid && (src_haz || waw) && !sb.flush;
  end

  assign fire = sb.issue_valid && !stall && !sb.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (!sb.flush && (|uflow_v)) err_q <= 1'b1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sb.issue_stall   = stall;
  assign sb.busy_vec      = busy_v;
  assign sb.any_pending   = |busy_v;
  assign sb.err_underflow = err_q;
  assign sb.stall_count   = stall_cnt_q;
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised RAW/WAW hazard scoreboard for the next-generation RV32I pipeline; replaces the fixed single-issue stall logic.
- Tracks outstanding register writes per architectural register with small counters, so several in-flight writes (variable-latency units) are supported.
- Generates the issue-stage stall, with optional same-cycle writeback bypass.
- Sits between decode/issue and the writeback ports of the execution units.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- REG_IDX_W, 5, register index width; must equal $clog2(NUM_REGS).
- NUM_SRC, 2, source operands checked per issued instruction.
- NUM_WB, 2, writeback ports.
- CNT_W, 2, per-register outstanding-write counter width; max outstanding writes = 2^CNT_W-1.
- BYPASS, 1, when 1, a source being retired this cycle by its last pending write does not stall.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs  in  NUM_SRC*REG_IDX_W  source indices; slot i at [i*REG_IDX_W +: REG_IDX_W].
- issue_rs_used  in  NUM_SRC  per-source "operand is read".
- issue_rd_valid  in  1  instruction writes a register.
- issue_rd  in  REG_IDX_W  destination index.
- issue_stall  out  1  hold decode; issue fires when issue_valid & ~issue_stall.
- wb_valid  in  NUM_WB  writeback port j is active.
- wb_rd  in  NUM_WB*REG_IDX_W  writeback destination per port.
- flush  in  1  pipeline flush; discards all outstanding writes.
- busy_vec  out  NUM_REGS  bit r = register r has count != 0.
- any_pending  out  1  OR of busy_vec.
- err_underflow  out  1  sticky: writeback hit a register with count 0.
- stall_count  out  32  saturating count of stalled cycles.

Behaviour:
- Reset: all counters 0; busy_vec=0, any_pending=0, err_underflow=0, stall_count=0. Reset has priority over flush, issue and wb. Asserting reset mid-operation discards all pending state in one cycle.
- Register 0: never becomes busy. Issue or wb to index 0 is ignored. A source reading index 0 never stalls.
- Source hazard for source i: issue_rs_used[i], rs != 0, and count[rs] > 0.
  - Exception when BYPASS=1: count[rs]==1 and at least one wb port targets rs this cycle. In that case there is no hazard.
- WAW overflow: issue_rd_valid, rd != 0, and count[rd] == max → stall.
- issue_stall = issue_valid & (any source hazard | WAW overflow) & ~flush. It is combinational from current counters and the current wb inputs. It is 0 when issue_valid=0.
- Fire = issue_valid & ~issue_stall & ~flush.
- Counter update each cycle: next = count + inc − dec.
  - inc = fire & issue_rd_valid & rd==r.
  - dec = number of wb ports with wb_valid & wb_rd==r (duplicate ports count separately), clamped so the counter never goes below 0.
  - Simultaneous issue and wb to the same register are both applied.
- Underflow: wb to a register whose count is 0, or dec exceeding count+inc, sets err_underflow the next cycle. It stays set until reset.
- Latency:
  - Issued rd shows in busy_vec the cycle after fire.
  - Writeback clears busy the cycle after wb_valid.
  - Sources are checked against pre-update state, so an instruction reading its own rd does not self-stall.
- Flush: all counters go to 0 next cycle. Issue and wb in the flush cycle are ignored. err_underflow and stall_count are not cleared.
- stall_count increments on every cycle with issue_valid & issue_stall and saturates at 32'hFFFF_FFFF.

Decomposition:
- Package sb_pkg:
  - constants NUM_REGS_DEF, REG_IDX_W_DEF, ZERO_REG=0.
  - typedef reg_idx_t (logic [REG_IDX_W-1:0]).
  - function for the wb-match popcount.
- Sub-module sb_entry, one per register r in 1..NUM_REGS-1 via generate:
  - holds the CNT_W counter.
  - inputs inc, dec count, flush, reset.
  - outputs count, busy, full, underflow pulse.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → busy_vec=0, issue_stall=0, stall_count=0, err_underflow=0.
- RAW stall: issue rd=5 (fire) at T, then rs1=5 used at T+1 → issue_stall=1; wb_valid[0], wb_rd=5 at T+3:
  - BYPASS=1 → stall drops in T+3.
  - BYPASS=0 → stall drops in T+4.
  - stall_count=2 or 3 respectively.
- Multiple outstanding (CNT_W=2): three issues to rd=7 → count 3; fourth issue to rd=7 stalls (WAW full); one wb to 7 → fourth fires next cycle; busy_vec[7] stays 1 until three further wbs.
- x0 and dual wb: issue rd=0 → busy_vec=0. Issue rd=3 twice, then both wb ports hit 3 in one cycle → busy_vec[3]=0 next cycle, err_underflow=0.
- Flush: registers 2, 4, 9 busy, flush=1 together with an issue rd=6 → next cycle busy_vec=0, any_pending=0, rd=6 not busy.
- Underflow: wb_valid[1], wb_rd=12 with count 0 → err_underflow=1 next cycle, remains 1 after a flush, cleared only by reset.
